// File: rtl/serial_nmi_ctrl.sv
// serial_nmi_ctrl: serial incrementer that walks an S-bit operand two bits
// per cycle through one shared 2-bit increment cell, LSB slice first.
// Result s = (a + 1) mod 2^S, co = carry-out; done pulses for one cycle.
// Optional build macro: EARLY_EXIT_EN -- stop as soon as the carry dies
// (upper slices already hold their final value), shortening latency.

// Shared 2-bit incrementer cell: {c_o, s_o} = x_i + c_i.
module serial_nmi_inc2 (
  input  logic [1:0] x_i,
  input  logic       c_i,
  output logic [1:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, x_i} + {2'b00, c_i};
endmodule

module serial_nmi_ctrl #(
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] a,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [S-1:0] s,
  output logic         co
);

  localparam int N  = S / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [S-1:0]    work_q;
  logic            carry_q;
  logic [KW-1:0]   k_q;

  logic [1:0]      slice_x;
  logic [1:0]      cell_s;
  logic            cell_c;
  logic [S-1:0]    work_d;
  logic            last_slice;
  logic            exit_run;

  // Select slice k of the work register and splice the cell sum back in.
  always_comb begin
    slice_x = 2'b00;
    work_d  = work_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        slice_x           = work_q[2*i +: 2];
        work_d[2*i +: 2]  = cell_s;
      end
    end
  end

  serial_nmi_inc2 u_cell (
    .x_i (slice_x),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  assign last_slice = (k_q == KW'(N - 1));

`ifdef EARLY_EXIT_EN
  // Once the carry is absorbed the remaining slices are already final.
  assign exit_run = last_slice || !cell_c;
`else
  assign exit_run = last_slice;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s       <= '0;
      co      <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work_q  <= a;
            k_q     <= '0;
            carry_q <= 1'b1;
            state_q <= RUN;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= cell_c;
          if (!last_slice) k_q <= k_q + KW'(1);
          if (exit_run) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            s       <= work_d;
            co      <= cell_c;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nmi_ctrl.sv
// Scoreboard bench for serial_nmi_ctrl (S=8). Expected results are pushed
// when a start is seen accepted and popped when done pulses.
module tb_serial_nmi_ctrl;
  localparam int S = 8;
  localparam int N = S / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [S-1:0] a = '0;
  logic         ready, busy, done, co;
  logic [S-1:0] s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [S-1:0] s;
    logic         co;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];

  serial_nmi_ctrl #(.S(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int model_lat(input logic [S-1:0] v);
`ifdef EARLY_EXIT_EN
    logic [S-1:0] t;
    t = v;
    for (int k = 0; k < N; k++)
      if (t[2*k +: 2] != 2'b11) return k + 1;
    return N;
`else
    return N;
`endif
  endfunction

  // Scoreboard push on acceptance, pop/compare on done.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_done: done=1 with no pending op at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (s !== e.s) begin
          errors++; $display("FAIL result_s: got %h expected %h", s, e.s);
        end
        checks++;
        if (co !== e.co) begin
          errors++; $display("FAIL result_co: got %b expected %b", co, e.co);
        end
        checks++;
        if ((cyc - e.acc) !== e.lat) begin
          errors++; $display("FAIL latency: got %0d expected %0d", cyc - e.acc, e.lat);
        end
      end
    end
    if (rst_n && start && ready) begin
      exp_t e;
      {e.co, e.s} = {1'b0, a} + (S+1)'(1);
      e.acc = cyc + 1;
      e.lat = model_lat(a);
      q.push_back(e);
    end
  end

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && !(q.size() == 0 && ready); i++) @(posedge clk) #1;
    checks++;
    if (q.size() != 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d ready=%b expected pending=0 ready=1", tag, q.size(), ready);
    end
  endtask

  task automatic run_op(input logic [S-1:0] v);
    for (int i = 0; i < 60 && !ready; i++) @(posedge clk) #1;
    start = 1'b1;
    a     = v;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk) #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", ready); end
    checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done  !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (s     !== '0)   begin errors++; $display("FAIL rst_s: got %h expected 00", s); end
    checks++; if (co    !== 1'b0) begin errors++; $display("FAIL rst_co: got %b expected 0", co); end
    // Release reset with start already high: first edge must accept.
    rst_n = 1'b1;
    start = 1'b1;
    a     = 8'h00;
    @(posedge clk) #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_accept: busy=%b expected 1", busy); end
    wait_idle("reset_release");
  endtask

  task automatic test_basic();
    logic [S-1:0] pats [5];
    pats = '{8'hFF, 8'h0F, 8'h3F, 8'h80, 8'hFE};
    foreach (pats[i]) begin
      run_op(pats[i]);
      checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
        errors++; $display("FAIL run_flags: busy=%b ready=%b expected busy=1 ready=0", busy, ready);
      end
      wait_idle("basic");
    end
    for (int i = 0; i < 4; i++) begin
      run_op(S'($urandom));
      wait_idle("random");
    end
  endtask

  task automatic test_ignore_during_run();
    run_op(8'h3A);
    start = 1'b1;
    a     = 8'h55;
    for (int i = 0; i <= N; i++) begin
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL ready_in_run: got %b expected 0 (step %0d)", ready, i); end
      @(posedge clk) #1;
    end
    start = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %b expected 1", ready); end
    wait_idle("ignore");
  endtask

  task automatic test_reset_mid_run();
    run_op(8'hFF);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", ready); end
    checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (s     !== '0)   begin errors++; $display("FAIL mid_rst_s: got %h expected 00", s); end
    checks++; if (co    !== 1'b0) begin errors++; $display("FAIL mid_rst_co: got %b expected 0", co); end
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk) #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_after_abort: got %b expected 0", done); end
    end
    run_op(8'h7F);
    wait_idle("after_abort");
  endtask

  task automatic test_back_to_back();
    int acc[$];
    start = 1'b1;
    a     = 8'h01;
    for (int i = 0; i < 2 * (N + 2) + 1; i++) begin
      @(negedge clk);
      if (ready) acc.push_back(cyc + 1);
    end
    @(posedge clk) #1;
    start = 1'b0;
    checks++;
    if (acc.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d accepts expected 3", acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] !== N + 2) begin
          errors++; $display("FAIL b2b_spacing: got %0d expected %0d", acc[i] - acc[i-1], N + 2);
        end
      end
    end
    wait_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_nmi_ctrl.md
SERIAL_NMI_CTRL -- requirements
Module: serial_nmi_ctrl

Interface
REQ-001 SHALL have parameter: S, 8, operand width in bits; even, >= 2; n = S/2 slices.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to increment operand a; honoured only when ready=1.
REQ-005 SHALL have port: a  input  S  operand, sampled on the accepting edge only.
REQ-006 SHALL have port: ready  output  1  high in IDLE, when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while slices are being processed (RUN).
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking a new result on s/co.
REQ-009 SHALL have port: s  output  S  registered result (a + 1) mod 2^S.
REQ-010 SHALL have port: co  output  1  registered carry-out of the increment.

Function
REQ-011 SHALL time-share one internal 2-bit incrementer cell (in: 2-bit slice plus carry; out: 2-bit sum plus carry) across all n slices, least-significant slice first.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the final slice; DONE->IDLE unconditionally next edge.
REQ-013 SHALL, on the accepting edge, latch a into a work register, clear slice index k to 0 and set the carry register to 1.
REQ-014 SHALL, on each RUN edge, replace work slice k with the cell sum, load the cell carry-out into the carry register and increment k.
REQ-015 SHALL leave RUN on the edge processing slice k = n-1 (k does not wrap).
REQ-016 SHALL load s and co from the work and carry registers on the edge entering DONE; done=1 during the DONE cycle only.
REQ-017 SHALL hold s and co stable at the previous result from acceptance until the next DONE entry.
REQ-018 SHALL give latency of exactly n cycles from the accepting edge to the edge entering DONE (EARLY_EXIT_EN undefined); next start is accepted no earlier than n+2 edges after the previous one.
REQ-019 SHALL ignore start while in RUN or DONE; no queuing, a not sampled.
REQ-020 SHALL produce s=0, co=1 for a = all ones and s=1, co=0 for a=0.
REQ-021 SHALL, with S=2 (n=1), spend exactly one cycle in RUN.
REQ-022 SHALL drive ready=1 only in IDLE and busy=1 only in RUN; they are never high together.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-RUN, immediately force state=IDLE, k=0, carry=0, work=0, s=0, co=0, done=0, busy=0, ready=1.
REQ-024 SHALL discard an in-flight operation aborted by reset; no done pulse follows release.
REQ-025 SHALL accept start on the first rising edge with rst_n=1.

Configuration
REQ-026 SHALL support the macro EARLY_EXIT_EN.
REQ-027 SHALL, with EARLY_EXIT_EN defined, leave RUN for DONE on the edge where the cell carry-out becomes 0 at k < n-1; untouched upper slices retain their a values; co=0; latency k+1 cycles.
REQ-028 SHALL, with EARLY_EXIT_EN undefined, always process all n slices (REQ-018); s/co results are identical in both builds, only latency differs.

Verification (S=8)
REQ-029 SHALL cover: start with a=0x00 -> s=0x01, co=0, done 4 cycles after acceptance (1 cycle with EARLY_EXIT_EN).
REQ-030 SHALL cover: start with a=0xFF -> s=0x00, co=1, done after 4 cycles in both builds.
REQ-031 SHALL cover: start with a=0x0F -> s=0x10, co=0, done after 4 cycles (3 with EARLY_EXIT_EN).
REQ-032 SHALL cover: start with a=0x3A, then start=1 with a=0x55 during RUN -> single done, s=0x3B; ready low until IDLE.
REQ-033 SHALL cover: rst_n pulsed low 2 cycles after accepting a=0xFF -> s=0, co=0, no done pulse, ready=1 immediately; a new start with a=0x7F then gives s=0x80, co=0.
REQ-034 SHALL cover: back-to-back starts held high continuously with a=0x01 -> accepted every n+2 cycles, each result s=0x02, co=0.
